// File: rtl/vector_pkg.sv
// Shared helpers for the vector-wide activation and serializer blocks:
// index-width derivation, element slice offsets and the serializer FSM encoding.
package vector_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  function automatic int calc_clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 32'sd1;
      end
    end
    return result;
  endfunction

  // A single-element vector still needs a one-bit index port.
  function automatic int index_width(input int count);
    return (calc_clog2(count) > 32'sd1) ? calc_clog2(count) : 32'sd1;
  endfunction

  function automatic int elem_lsb(input int index, input int width);
    return index * width;
  endfunction

endpackage

// File: rtl/vector_stream_serializer_if.sv
// Load/done side and valid/ready stream side of the vector stream serializer.
// master = serializer, slave = producer/consumer environment.
interface vector_stream_serializer_if #(
  parameter int ELEMENT_COUNT = 128,
  parameter int DATA_WIDTH    = 16
);
  localparam int INDEX_WIDTH = vector_pkg::index_width(ELEMENT_COUNT);

  logic                              load;
  logic [DATA_WIDTH*ELEMENT_COUNT-1:0] data_in;
  logic                              load_ready;
  logic                              m_valid;
  logic                              m_ready;
  logic [DATA_WIDTH-1:0]             m_data;
  logic [INDEX_WIDTH-1:0]            m_index;
  logic                              m_last;
  logic                              busy;
  logic                              done;

  modport master (
    input  load, data_in, m_ready,
    output load_ready, m_valid, m_data, m_index, m_last, busy, done
  );

  modport slave (
    output load, data_in, m_ready,
    input  load_ready, m_valid, m_data, m_index, m_last, busy, done
  );
endinterface

// File: rtl/vector_stream_serializer.sv
// Captures a flattened vector and streams it one element per beat with index/last tags.
// Define VECTOR_STREAM_SERIALIZER_DOUBLE_BUF_EN to add a shadow buffer for back-to-back vectors.
module vector_stream_serializer
  import vector_pkg::*;
#(
  parameter int ELEMENT_COUNT = 128,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  vector_stream_serializer_if.master  bus
);

  localparam int INDEX_WIDTH = index_width(ELEMENT_COUNT);
  localparam int VEC_WIDTH   = DATA_WIDTH * ELEMENT_COUNT;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(ELEMENT_COUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);
  localparam logic SINGLE_ELEM = 1'(ELEMENT_COUNT == 1);

`ifndef SYNTHESIS
  if (ELEMENT_COUNT < 1) begin : g_count_check
    $error("vector_stream_serializer: ELEMENT_COUNT must be > 0");
  end
`endif

  ser_state_e             state_r;
  ser_state_e             next_state_s;
  logic [VEC_WIDTH-1:0]   active_r;
  logic [INDEX_WIDTH-1:0] idx_r;
  logic [INDEX_WIDTH-1:0] nxt_idx_s;
  logic [DATA_WIDTH-1:0]  data_r;
  logic                   last_r;
  logic                   done_r;
  logic                   valid_s;
  logic                   busy_s;
  logic                   load_ready_s;
  logic                   load_acc_s;
  logic                   xfer_s;
  logic                   final_s;
  logic                   refill_s;
  logic                   begin_s;
  logic [VEC_WIDTH-1:0]   start_vec_s;

`ifdef VECTOR_STREAM_SERIALIZER_DOUBLE_BUF_EN
  logic [VEC_WIDTH-1:0]   shadow_r;
  logic                   shadow_full_r;

  // A waiting shadow vector takes priority; otherwise a coincident load starts directly.
  assign refill_s    = shadow_full_r || load_acc_s;
  assign start_vec_s = shadow_full_r ? shadow_r : bus.data_in;
`else
  assign refill_s    = 1'b0;
  assign start_vec_s = bus.data_in;
`endif

  assign load_acc_s = bus.load && load_ready_s;
  assign xfer_s     = valid_s && bus.m_ready;
  assign final_s    = xfer_s && last_r;
  assign begin_s    = ((state_r == ST_IDLE) && load_acc_s) || (final_s && refill_s);
  assign nxt_idx_s  = idx_r + ONE_IDX;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_acc_s) begin
          next_state_s = ST_STREAM;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (final_s && !refill_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_STREAM;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    valid_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      ST_STREAM: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
`ifdef VECTOR_STREAM_SERIALIZER_DOUBLE_BUF_EN
    load_ready_s = !shadow_full_r;
`else
    load_ready_s = !busy_s;
`endif
  end

  // Active buffer, element index and registered beat fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= '0;
      idx_r    <= '0;
      data_r   <= '0;
      last_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= final_s;
      if (begin_s) begin
        active_r <= start_vec_s;
        idx_r    <= '0;
        data_r   <= start_vec_s[DATA_WIDTH-1:0];
        last_r   <= SINGLE_ELEM;
      end else if (final_s) begin
        idx_r  <= '0;
        last_r <= 1'b0;
      end else if (xfer_s) begin
        idx_r  <= nxt_idx_s;
        data_r <= active_r[elem_lsb(int'(nxt_idx_s), DATA_WIDTH) +: DATA_WIDTH];
        last_r <= (nxt_idx_s == LAST_IDX);
      end
    end
  end

`ifdef VECTOR_STREAM_SERIALIZER_DOUBLE_BUF_EN
  // Shadow buffer holds the next vector while the active one drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r      <= '0;
      shadow_full_r <= 1'b0;
    end else if (final_s && shadow_full_r) begin
      shadow_full_r <= 1'b0;
    end else if (load_acc_s && valid_s && !final_s) begin
      shadow_r      <= bus.data_in;
      shadow_full_r <= 1'b1;
    end
  end
`endif

  assign bus.load_ready = load_ready_s;
  assign bus.m_valid    = valid_s;
  assign bus.busy       = busy_s;
  assign bus.m_data     = data_r;
  assign bus.m_index    = idx_r;
  assign bus.m_last     = last_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_vector_stream_serializer.sv
// Scoreboard bench: a vector-level model queues expected beats on each accepted load,
// a negedge monitor pops and compares them on every transfer.
module tb_vector_stream_serializer;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_stream_serializer_if #(.ELEMENT_COUNT(N), .DATA_WIDTH(W)) bus ();
  vector_stream_serializer_if #(.ELEMENT_COUNT(1), .DATA_WIDTH(W)) bus1 ();

  vector_stream_serializer #(.ELEMENT_COUNT(N), .DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vector_stream_serializer #(.ELEMENT_COUNT(1), .DATA_WIDTH(W)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  index;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // model state: vectors held (active + waiting), beat position, expected done
  int    held = 0;
  int    pos = 0;
  bit    exp_done = 1'b0;

  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [1:0]  prev_index;
  logic        prev_last;
  beat_t       e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit model_ready(input int h);
`ifdef VECTOR_STREAM_SERIALIZER_DOUBLE_BUF_EN
    return h < 2;
`else
    return h == 0;
`endif
  endfunction

  // Reference model: vector-granular bookkeeping
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        held     = 0;
        pos      = 0;
        exp_done = 1'b0;
        exp_q.delete();
      end else begin
        bit rdy;
        bit xf;
        bit fin;
        rdy = model_ready(held);
        xf  = (held > 0) && bus.m_ready;
        fin = xf && (pos == N - 1);
        exp_done = fin;
        if (xf) begin
          if (fin) begin
            held--;
            pos = 0;
          end else begin
            pos++;
          end
        end
        if (bus.load && rdy) begin
          held++;
          for (int i = 0; i < N; i++) begin
            exp_q.push_back('{data: bus.data_in[i*W +: W], index: 2'(i), last: 1'(i == N - 1)});
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      check("m_valid", 32'(bus.m_valid), 32'(held > 0));
      check("busy", 32'(bus.busy), 32'(held > 0));
      check("load_ready", 32'(bus.load_ready), 32'(model_ready(held)));
      check("done", 32'(bus.done), 32'(exp_done));
      if (rst) begin
        check("rst_m_data", 32'(bus.m_data), 32'h0);
        check("rst_m_index", 32'(bus.m_index), 32'h0);
        check("rst_m_last", 32'(bus.m_last), 32'h0);
      end
      if (prev_stall && bus.m_valid) begin
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
        check("stall_index", 32'(bus.m_index), 32'(prev_index));
        check("stall_last", 32'(bus.m_last), 32'(prev_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data 0x%0h index %0d, expected no beat", bus.m_data, bus.m_index);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(bus.m_data), 32'(e.data));
          check("beat_index", 32'(bus.m_index), 32'(e.index));
          check("beat_last", 32'(bus.m_last), 32'(e.last));
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_index = bus.m_index;
      prev_last  = bus.m_last;
    end
  end

  task automatic step(input bit ld, input bit rdy, input logic [63:0] vec);
    bus.load    = ld;
    bus.m_ready = rdy;
    bus.data_in = ld ? vec : {$urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] V1 = 64'h0400_0300_0200_0100;
  localparam logic [63:0] VB = 64'hF003_F002_F001_F000;
  localparam logic [63:0] VC = 64'h1111_2222_3333_4444;
  localparam logic [63:0] VD = 64'hABCD_0123_8000_7FFF;
  bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    bus.load     = 1'b0;
    bus.m_ready  = 1'b0;
    bus.data_in  = 64'h0;
    bus1.load    = 1'b0;
    bus1.m_ready = 1'b0;
    bus1.data_in = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // full-rate stream
    step(1'b1, 1'b1, V1);
    repeat (7) step(1'b0, 1'b1, 64'h0);

    // backpressure pattern
    step(1'b1, 1'b1, V1);
    for (int i = 0; i < 7; i++) step(1'b0, pat[i], 64'h0);
    repeat (4) step(1'b0, 1'b1, 64'h0);

    // second load while busy
    step(1'b1, 1'b1, V1);
    step(1'b1, 1'b1, VB);
    repeat (10) step(1'b0, 1'b1, 64'h0);

    // reset after two beats, then restart
    step(1'b1, 1'b1, VC);
    step(1'b0, 1'b1, 64'h0);
    step(1'b0, 1'b1, 64'h0);
    rst = 1'b1;
    step(1'b0, 1'b1, 64'h0);
    rst = 1'b0;
    step(1'b1, 1'b1, VD);
    repeat (6) step(1'b0, 1'b1, 64'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
    end
    repeat (20) step(1'b0, 1'b1, 64'h0);
    check("drain_empty", 32'(exp_q.size()), 32'h0);

    // single-element vector
    @(negedge clk);
    check("n1_idle_valid", 32'(bus1.m_valid), 32'h0);
    check("n1_idle_ready", 32'(bus1.load_ready), 32'h1);
    @(posedge clk);
    #1;
    bus1.data_in = 16'h7FFF;
    bus1.load    = 1'b1;
    bus1.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.load    = 1'b0;
    bus1.data_in = 16'h1234;
    @(negedge clk);
    check("n1_valid", 32'(bus1.m_valid), 32'h1);
    check("n1_data", 32'(bus1.m_data), 32'h7FFF);
    check("n1_index", 32'(bus1.m_index), 32'h0);
    check("n1_last", 32'(bus1.m_last), 32'h1);
    check("n1_done_early", 32'(bus1.done), 32'h0);
    @(negedge clk);
    check("n1_valid_after", 32'(bus1.m_valid), 32'h0);
    check("n1_busy_after", 32'(bus1.busy), 32'h0);
    check("n1_done", 32'(bus1.done), 32'h1);
    @(negedge clk);
    check("n1_done_pulse", 32'(bus1.done), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
